// File: rtl/scumv_proto_router.sv
// rtl/scumv_proto_router.sv - tag-prefixed request/response router between host UART FIFOs and NUM_CH channels
// Optional response watchdog: define SCUMV_ROUTER_TIMEOUT_EN.
module scumv_proto_router #(
    parameter int                   NUM_CH         = 3,
    // Channel 0 occupies the least-significant slice of each packed table.
    parameter logic [NUM_CH*24-1:0] CH_TAGS        = {"dbg", "stl", "asc"},
    parameter logic [NUM_CH*8-1:0]  REQ_LEN        = {8'd4, 8'd16, 8'd22},
    parameter logic [NUM_CH*8-1:0]  RESP_LEN       = {8'd4, 8'd16, 8'd1},
    parameter logic [7:0]           SEP_CHAR       = 8'h2B,
    parameter int                   TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]           ERR_BYTE       = 8'hEE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [7:0]            ch_req_data,
    output logic [NUM_CH-1:0]     ch_req_valid,
    input  logic [NUM_CH-1:0]     ch_req_ready,
    input  logic [8*NUM_CH-1:0]   ch_resp_data,
    input  logic [NUM_CH-1:0]     ch_resp_valid,
    output logic [NUM_CH-1:0]     ch_resp_ready,
    output logic [2:0]            active_ch,
    output logic                  busy,
    output logic [15:0]           txn_count,
    output logic [7:0]            err_count
);

    typedef enum logic [2:0] {
        IDLE,
        P1,
        P2,
        P3,
        FWD,
        RESP
`ifdef SCUMV_ROUTER_TIMEOUT_EN
        ,
        ERR
`endif
    } state_t;

    state_t              state, state_n;
    logic [NUM_CH-1:0]   mask, mask_n;
    logic [2:0]          sel, sel_n;
    logic [7:0]          cnt, cnt_n;
    logic [15:0]         txn_n;
    logic                err_inc;
    logic                resync;

    logic [NUM_CH-1:0]   m1, m2, m3;
    logic [2:0]          low;
    logic [7:0]          req_len_sel, resp_len_sel, resp_data_sel;
    logic                req_ready_sel, resp_valid_sel;

`ifdef SCUMV_ROUTER_TIMEOUT_EN
    localparam logic [19:0] WDOG_LIM = 20'(TIMEOUT_CYCLES - 1);
    logic [19:0]         wdog, wdog_n;
`endif

    assign ch_req_data = rx_data;
    assign active_ch   = sel;

    // Per-channel tag character matches, lowest candidate, and selected-channel muxes.
    always_comb begin
        m1             = '0;
        m2             = '0;
        m3             = '0;
        low            = 3'd0;
        req_len_sel    = 8'd0;
        resp_len_sel   = 8'd0;
        resp_data_sel  = 8'd0;
        req_ready_sel  = 1'b0;
        resp_valid_sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            m1[i] = (rx_data == CH_TAGS[24*i+16 +: 8]);
            m2[i] = (rx_data == CH_TAGS[24*i+8 +: 8]);
            m3[i] = (rx_data == CH_TAGS[24*i +: 8]);
            if (sel == 3'(i)) begin
                req_len_sel    = REQ_LEN[8*i +: 8];
                resp_len_sel   = RESP_LEN[8*i +: 8];
                resp_data_sel  = ch_resp_data[8*i +: 8];
                req_ready_sel  = ch_req_ready[i];
                resp_valid_sel = ch_resp_valid[i];
            end
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) low = 3'(i);
        end
    end

    // Next-state, counters and pass-through handshake outputs.
    always_comb begin
        state_n       = state;
        mask_n        = mask;
        sel_n         = sel;
        cnt_n         = cnt;
        txn_n         = txn_count;
        err_inc       = 1'b0;
        resync        = 1'b0;
        rx_ready      = 1'b0;
        tx_valid      = 1'b0;
        tx_data       = 8'h00;
        ch_req_valid  = '0;
        ch_resp_ready = '0;
        busy          = 1'b0;
`ifdef SCUMV_ROUTER_TIMEOUT_EN
        wdog_n        = wdog;
`endif
        case (state)
            IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid) resync = 1'b1;
            end
            P1: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if ((mask & m2) != '0) begin
                        mask_n  = mask & m2;
                        state_n = P2;
                    end else begin
                        err_inc = 1'b1;
                        resync  = 1'b1;
                    end
                end
            end
            P2: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if ((mask & m3) != '0) begin
                        mask_n  = mask & m3;
                        state_n = P3;
                    end else begin
                        err_inc = 1'b1;
                        resync  = 1'b1;
                    end
                end
            end
            P3: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (rx_data == SEP_CHAR && mask != '0) begin
                        sel_n   = low;
                        cnt_n   = 8'd0;
                        state_n = FWD;
                    end else begin
                        err_inc = 1'b1;
                        resync  = 1'b1;
                    end
                end
            end
            FWD: begin
                busy     = 1'b1;
                rx_ready = req_ready_sel;
                for (int i = 0; i < NUM_CH; i++) begin
                    ch_req_valid[i] = rx_valid && (sel == 3'(i));
                end
                if (rx_valid && req_ready_sel) begin
                    if ((cnt + 8'd1) == req_len_sel) begin
                        cnt_n = 8'd0;
                        if (resp_len_sel == 8'd0) begin
                            state_n = IDLE;
                            txn_n   = txn_count + 16'd1;
                        end else begin
                            state_n = RESP;
`ifdef SCUMV_ROUTER_TIMEOUT_EN
                            wdog_n  = 20'd0;
`endif
                        end
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
            end
            RESP: begin
                busy     = 1'b1;
                tx_valid = resp_valid_sel;
                tx_data  = resp_data_sel;
                for (int i = 0; i < NUM_CH; i++) begin
                    ch_resp_ready[i] = tx_ready && (sel == 3'(i));
                end
                if (resp_valid_sel && tx_ready) begin
`ifdef SCUMV_ROUTER_TIMEOUT_EN
                    wdog_n = 20'd0;
`endif
                    if ((cnt + 8'd1) == resp_len_sel) begin
                        cnt_n   = 8'd0;
                        state_n = IDLE;
                        txn_n   = txn_count + 16'd1;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
`ifdef SCUMV_ROUTER_TIMEOUT_EN
                else if (wdog == WDOG_LIM) begin
                    state_n = ERR;
                end else begin
                    wdog_n = wdog + 20'd1;
                end
`endif
            end
`ifdef SCUMV_ROUTER_TIMEOUT_EN
            ERR: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = ERR_BYTE;
                if (tx_ready) begin
                    err_inc = 1'b1;
                    cnt_n   = 8'd0;
                    state_n = IDLE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
        // A failed prefix byte is re-examined as a potential first tag char.
        if (resync) begin
            if (m1 != '0) begin
                mask_n  = m1;
                state_n = P1;
            end else begin
                mask_n  = '0;
                state_n = IDLE;
            end
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mask      <= '0;
            sel       <= 3'd0;
            cnt       <= 8'd0;
            txn_count <= 16'd0;
            err_count <= 8'd0;
        end else begin
            state     <= state_n;
            mask      <= mask_n;
            sel       <= sel_n;
            cnt       <= cnt_n;
            txn_count <= txn_n;
            if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

`ifdef SCUMV_ROUTER_TIMEOUT_EN
    // Response watchdog register.
    always_ff @(posedge clk) begin
        if (reset) wdog <= 20'd0;
        else       wdog <= wdog_n;
    end
`endif

endmodule

// File: tb/tb_scumv_proto_router.sv
// tb/tb_scumv_proto_router.sv - scoreboard bench for scumv_proto_router
module tb_scumv_proto_router;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  ch_req_data;
    logic [2:0]  ch_req_valid;
    logic [2:0]  ch_req_ready;
    logic [23:0] ch_resp_data;
    logic [2:0]  ch_resp_valid;
    logic [2:0]  ch_resp_ready;
    logic [2:0]  active_ch;
    logic        busy;
    logic [15:0] txn_count;
    logic [7:0]  err_count;

    int total = 0;
    int bad   = 0;

    logic [9:0]  exp_req[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  rsp_q[$];
    int          rsp_ch = 0;
    logic        resp_pop = 1'b0;
    logic        tx_toggle = 1'b0;

    scumv_proto_router #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ch_req_data(ch_req_data), .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready),
        .ch_resp_data(ch_resp_data), .ch_resp_valid(ch_resp_valid), .ch_resp_ready(ch_resp_ready),
        .active_ch(active_ch), .busy(busy), .txn_count(txn_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Channel responder and tx_ready driver, updated just after each rising edge.
    initial begin
        tx_ready      = 1'b1;
        ch_resp_valid = '0;
        ch_resp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_pop && rsp_q.size() > 0) void'(rsp_q.pop_front());
            tx_ready      = tx_toggle ? ~tx_ready : 1'b1;
            ch_resp_valid = '0;
            ch_resp_data  = '0;
            if (rsp_q.size() > 0) begin
                ch_resp_valid[rsp_ch]         = 1'b1;
                ch_resp_data[8*rsp_ch +: 8]   = rsp_q[0];
            end
        end
    end

    // Monitor: compares every request and tx handshake against the expected queues.
    initial begin
        forever begin
            @(negedge clk);
            resp_pop = ch_resp_valid[rsp_ch] && ch_resp_ready[rsp_ch];
            if (!reset) begin
                if ($countones(ch_req_valid) > 1) chk("req_onehot", {29'd0, ch_req_valid}, 32'd0);
                if (ch_resp_ready != 3'b000)
                    chk("resp_ready_ch", {29'd0, ch_resp_ready & ~(3'b001 << rsp_ch)}, 32'd0);
                for (int i = 0; i < 3; i++) begin
                    if (ch_req_valid[i] && ch_req_ready[i]) begin
                        if (exp_req.size() == 0) chk("unexpected_req", {22'd0, 2'(i), ch_req_data}, 32'h3FF);
                        else chk("req", {22'd0, 2'(i), ch_req_data}, {22'd0, exp_req.pop_front()});
                    end
                end
                if (tx_valid && tx_ready) begin
                    if (exp_tx.size() == 0) chk("unexpected_tx", {24'd0, tx_data}, 32'h100);
                    else chk("tx", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int  n    = 0;
        logic done = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            done = rx_ready;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 2000) begin
                chk("send_timeout", 32'(n), 32'd0);
                done = 1'b1;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (!busy && exp_tx.size() == 0 && exp_req.size() == 0) break;
            n++;
            if (n > 500) begin
                chk("idle_timeout", {31'd0, busy}, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic run_txn(input string hdr, input int ch, input int nreq, input logic [7:0] req_base,
                           input int nresp, input logic [7:0] resp_base);
        rsp_ch = ch;
        for (int i = 0; i < nresp; i++) rsp_q.push_back(resp_base + 8'(i));
        send_str(hdr);
        for (int i = 0; i < nreq; i++) begin
            exp_req.push_back({2'(ch), req_base + 8'(i)});
            send_byte(req_base + 8'(i));
        end
        for (int i = 0; i < nresp; i++) exp_tx.push_back(resp_base + 8'(i));
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd1);
        chk({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
        chk({tag, "_req_valid"}, {29'd0, ch_req_valid}, 32'd0);
        chk({tag, "_resp_ready"}, {29'd0, ch_resp_ready}, 32'd0);
        chk({tag, "_active_ch"}, {29'd0, active_ch}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_txn"}, {16'd0, txn_count}, 32'd0);
        chk({tag, "_err"}, {24'd0, err_count}, 32'd0);
    endtask

    initial begin
        logic stall_ok;
        reset        = 1'b1;
        rx_data      = 8'h00;
        rx_valid     = 1'b0;
        ch_req_ready = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // asc: 22 request bytes 0x00..0x15, one response byte 0x5A
        rsp_ch = 0;
        rsp_q.push_back(8'h5A);
        send_str("asc+");
        @(negedge clk);
        chk("asc_busy", {31'd0, busy}, 32'd1);
        chk("asc_active", {29'd0, active_ch}, 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 22; i++) begin
            exp_req.push_back({2'd0, 8'(i)});
            send_byte(8'(i));
        end
        exp_tx.push_back(8'h5A);
        wait_idle();
        chk("asc_txn", {16'd0, txn_count}, 32'd1);
        chk("asc_err", {24'd0, err_count}, 32'd0);

        // stl with tx_ready toggling every cycle
        tx_toggle = 1'b1;
        run_txn("stl+", 1, 16, 8'h30, 16, 8'hA0);
        tx_toggle = 1'b0;
        chk("stl_busy", {31'd0, busy}, 32'd0);
        chk("stl_txn", {16'd0, txn_count}, 32'd2);

        // prefix resync: 'x' discarded, "as"+'s' aborts, 's' restarts stl
        run_txn("xasstl+", 1, 16, 8'h60, 16, 8'hC0);
        chk("resync_err", {24'd0, err_count}, 32'd1);
        chk("resync_txn", {16'd0, txn_count}, 32'd3);

        // dbg with ch2 request ready held low for 10 cycles
        rsp_ch = 2;
        for (int i = 0; i < 4; i++) rsp_q.push_back(8'hD0 + 8'(i));
        ch_req_ready = 3'b011;
        send_str("dbg+");
        for (int i = 0; i < 4; i++) exp_req.push_back({2'd2, 8'h10 + 8'(i)});
        rx_data  = 8'h10;
        rx_valid = 1'b1;
        stall_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rx_ready || ch_req_valid != 3'b100) stall_ok = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("stall_hold", {31'd0, stall_ok}, 32'd1);
        chk("stall_no_consume", 32'(exp_req.size()), 32'd4);
        ch_req_ready = 3'b111;
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
        for (int i = 0; i < 4; i++) exp_tx.push_back(8'hD0 + 8'(i));
        wait_idle();
        chk("dbg_txn", {16'd0, txn_count}, 32'd4);

`ifdef SCUMV_ROUTER_TIMEOUT_EN
        // dbg with silent channel: watchdog emits the error byte
        rsp_ch = 2;
        send_str("dbg+");
        for (int i = 0; i < 4; i++) begin
            exp_req.push_back({2'd2, 8'h20 + 8'(i)});
            send_byte(8'h20 + 8'(i));
        end
        exp_tx.push_back(8'hEE);
        wait_idle();
        chk("to_err", {24'd0, err_count}, 32'd2);
        chk("to_txn", {16'd0, txn_count}, 32'd4);
        run_txn("asc+", 0, 22, 8'h40, 1, 8'h77);
        chk("to_after_txn", {16'd0, txn_count}, 32'd5);
`endif

        // reset in the middle of an stl request
        rsp_ch = 1;
        send_str("stl+");
        for (int i = 0; i < 5; i++) begin
            exp_req.push_back({2'd1, 8'h50 + 8'(i)});
            send_byte(8'h50 + 8'(i));
        end
        ch_req_ready = 3'b101;
        rx_data      = 8'h00;
        rx_valid     = 1'b1;
        reset        = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        reset        = 1'b0;
        rx_valid     = 1'b0;
        ch_req_ready = 3'b111;
        run_txn("asc+", 0, 22, 8'h80, 1, 8'h5A);
        chk("post_rst_txn", {16'd0, txn_count}, 32'd1);
        chk("post_rst_err", {24'd0, err_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
